// File: rtl/spi_stream_peripheral.sv
// SPI target for the OCR front end: receives fixed-length frames of DATA_W-bit
// words on COPI, streams them out over valid/ready, and replies full-duplex on
// CIPO from a tx valid/ready source. Supports all four SPI modes and either
// bit order, and aborts cleanly on early CS release or an SCLK timeout.
//
// Handshakes:
//   rx: a word transfers on any cycle where rx_valid && rx_ready. While rx_valid
//       is high and rx_ready low, rx_data holds; a word landing then is dropped
//       and flagged in overflow.
//   tx: tx_ready is a combinational one-cycle pulse marking the cycle in which
//       tx_data is captured (only when tx_valid is high); a load with tx_valid
//       low sends zeros and flags underrun.
module spi_stream_peripheral #(
    parameter int DATA_W         = 8,
    parameter int FRAME_WORDS    = 113,
    parameter int CPOL           = 0,
    parameter int CPHA           = 0,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sclk,
    input  logic                               copi,
    input  logic                               cs_n,
    output logic                               cipo,
    output logic                               cipo_oe,
    input  logic                               rx_enable,
    output logic [DATA_W-1:0]                  rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    input  logic [DATA_W-1:0]                  tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic [$clog2(FRAME_WORDS+1)-1:0]   word_count,
    output logic                               frame_done,
    output logic                               frame_abort,
    output logic                               overflow,
    output logic                               underrun
);

    localparam int   CW       = $clog2(FRAME_WORDS + 1);
    localparam int   BW       = $clog2(DATA_W);
    localparam int   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic IDLE_LVL = (CPOL != 0);
    localparam logic PHA      = (CPHA != 0);
    localparam logic MSB      = (MSB_FIRST != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    // [0] first sync stage, [1] synchronised value, [2] history for edge detect
    logic [2:0] sclk_sync_q, copi_sync_q, cs_sync_q;
    logic [1:0] prime_q;

    state_t            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_abort_q, frame_abort_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              lead_edge, trail_edge, sample_edge, shift_edge, any_edge;
    logic              cs_fall, cs_rise, cs_high, copi_s;
    logic [DATA_W-1:0] rx_shifted, tx_shifted;
    logic              tmo_hit, tx_load, frame_complete;

    assign lead_edge   = (sclk_sync_q[2] == IDLE_LVL) && (sclk_sync_q[1] != IDLE_LVL);
    assign trail_edge  = (sclk_sync_q[2] != IDLE_LVL) && (sclk_sync_q[1] == IDLE_LVL);
    assign sample_edge = PHA ? trail_edge : lead_edge;
    assign shift_edge  = PHA ? lead_edge : trail_edge;
    assign any_edge    = lead_edge || trail_edge;
    assign cs_fall     = cs_sync_q[2] && !cs_sync_q[1];
    assign cs_rise     = !cs_sync_q[2] && cs_sync_q[1];
    assign cs_high     = cs_sync_q[1];
    // COPI is stable around the sample edge, so the history stage is safe to use
    assign copi_s      = copi_sync_q[2];

    assign rx_shifted = MSB ? {rx_sr_q[DATA_W-2:0], copi_s} : {copi_s, rx_sr_q[DATA_W-1:1]};
    assign tx_shifted = MSB ? {tx_sr_q[DATA_W-2:0], 1'b0} : {1'b0, tx_sr_q[DATA_W-1:1]};
    assign tmo_hit    = (state_q == S_ACTIVE) && !any_edge && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Synchronise the asynchronous SPI pins; cs idles high, sclk idles at CPOL
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {3{IDLE_LVL}};
            copi_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            copi_sync_q <= {copi_sync_q[1:0], copi};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
        end
    end

    // Count sync fill after reset so a cs_n already low is not seen as a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_q <= 2'd0;
        end else if (prime_q != 2'd3) begin
            prime_q <= prime_q + 2'd1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            rx_sr_q       <= '0;
            tx_sr_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            overflow_q    <= 1'b0;
            underrun_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            rx_sr_q       <= rx_sr_d;
            tx_sr_q       <= tx_sr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            overflow_q    <= overflow_d;
            underrun_q    <= underrun_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            tmo_q         <= tmo_d;
        end
    end

    // Next-state, shift registers, word hand-off, TX loads and abort handling
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        word_cnt_d     = word_cnt_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        overflow_d     = overflow_q;
        underrun_d     = underrun_q;
        frame_done_d   = 1'b0;
        frame_abort_d  = 1'b0;
        tx_load        = 1'b0;
        frame_complete = 1'b0;
        tmo_d          = ((state_q == S_ACTIVE) && !any_edge) ? tmo_q + TW'(1) : '0;

        // Consumer accepted the current word; a word landing below overrides this
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    if (rx_enable && (prime_q == 2'd3)) begin
                        state_d    = S_ACTIVE;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                        rx_sr_d    = '0;
                        overflow_d = 1'b0;
                        underrun_d = 1'b0;
                        // CPHA=0 needs the first bit on CIPO before the first edge
                        tx_load    = !PHA;
                    end else begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ACTIVE: begin
                if (sample_edge) begin
                    rx_sr_d = rx_shifted;
                    if (bit_cnt_q == BW'(DATA_W - 1)) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + CW'(1);
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_shifted;
                            rx_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        frame_complete = (word_cnt_q == CW'(FRAME_WORDS - 1));
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                // bit_cnt==0 on a shift edge marks the TX word boundary in both phases
                if (shift_edge) begin
                    if (bit_cnt_q == '0) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_sr_d = tx_shifted;
                    end
                end
                if (frame_complete) begin
                    state_d = S_DONE;
                end else if (cs_rise) begin
                    frame_abort_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (tmo_hit) begin
                    frame_abort_d = 1'b1;
                    state_d       = S_ABORT;
                end
            end
            S_DONE: begin
                if (cs_high) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_ABORT: begin
                if (cs_high) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tx_load) begin
            if (tx_valid) begin
                tx_sr_d = tx_data;
            end else begin
                tx_sr_d    = '0;
                underrun_d = 1'b1;
            end
        end
    end

    assign cipo        = (state_q == S_ACTIVE) && (MSB ? tx_sr_q[DATA_W-1] : tx_sr_q[0]);
    assign cipo_oe     = (state_q == S_ACTIVE);
    assign tx_ready    = tx_load && tx_valid;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign word_count  = word_cnt_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign overflow    = overflow_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_spi_stream_peripheral.sv
// Bench for spi_stream_peripheral: instance 0 is mode 0, MSB first, 3-word
// frames, 50-cycle timeout; instances 1..4 are modes 0..3, LSB first, 2-word
// frames. A bench-side SPI controller drives one instance at a time.
module tb_spi_stream_peripheral;

    localparam int W  = 8;
    localparam int NI = 5;
    localparam int H  = 8;   // SCLK half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0] sclk_v, cs_n_v, rx_ready_v, tx_valid_v, rx_enable_v;
    logic          copi;
    logic [NI-1:0] cipo_v, cipo_oe_v, rx_valid_v, tx_ready_v;
    logic [NI-1:0] frame_done_v, frame_abort_v, overflow_v, underrun_v;
    logic [W-1:0]  rx_data_v  [NI];
    logic [W-1:0]  tx_data_v  [NI];
    logic [1:0]    word_count_v [NI];

    logic [W-1:0]  tx_seq [NI][3];
    int            tx_ptr [NI] = '{default: 0};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int MODE = (g == 0) ? 0 : g - 1;
        assign tx_data_v[g] = tx_seq[g][tx_ptr[g]];
        spi_stream_peripheral #(
            .DATA_W(W),
            .FRAME_WORDS((g == 0) ? 3 : 2),
            .CPOL(MODE / 2),
            .CPHA(MODE % 2),
            .MSB_FIRST((g == 0) ? 1 : 0),
            .TIMEOUT_CYCLES((g == 0) ? 50 : 1000)
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk_v[g]), .copi(copi), .cs_n(cs_n_v[g]),
            .cipo(cipo_v[g]), .cipo_oe(cipo_oe_v[g]), .rx_enable(rx_enable_v[g]),
            .rx_data(rx_data_v[g]), .rx_valid(rx_valid_v[g]), .rx_ready(rx_ready_v[g]),
            .tx_data(tx_data_v[g]), .tx_valid(tx_valid_v[g]), .tx_ready(tx_ready_v[g]),
            .word_count(word_count_v[g]), .frame_done(frame_done_v[g]),
            .frame_abort(frame_abort_v[g]), .overflow(overflow_v[g]), .underrun(underrun_v[g])
        );
    end

    // TX source: step to the next table word after each consumed word
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (tx_ready_v[g] && tx_ptr[g] < 2) tx_ptr[g] <= tx_ptr[g] + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pulse counters and received-word capture
    int           done_cnt [NI] = '{default: 0};
    int           abort_cnt[NI] = '{default: 0};
    int           txr_cnt  [NI] = '{default: 0};
    int           rxw_cnt  [NI] = '{default: 0};
    int           cur_idx = 0;
    logic [W-1:0] got_q[$];
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (frame_done_v[g])  done_cnt[g]++;
            if (frame_abort_v[g]) abort_cnt[g]++;
            if (tx_ready_v[g])    txr_cnt[g]++;
            if (rx_valid_v[g] && rx_ready_v[g]) begin
                rxw_cnt[g]++;
                if (g == cur_idx) got_q.push_back(rx_data_v[g]);
            end
        end
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int           got_rd = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           last_edge_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [W-1:0] e;
        check_eq({tag, "_rx_count"}, got_q.size() - got_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_q.size()) begin
                check_eq({tag, "_rx_word"}, got_q[got_rd], e);
                got_rd++;
            end
        end
        got_rd = got_q.size();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic pol_of(input int idx);
        return (idx == 0) ? 1'b0 : ((idx - 1) >= 2);
    endfunction
    function automatic logic pha_of(input int idx);
        return (idx == 0) ? 1'b0 : (((idx - 1) % 2) == 1);
    endfunction

    task automatic sclk_set(input int idx, input logic v);
        sclk_v[idx]   = v;
        last_edge_cyc = cyc;
    endtask

    // One word (or its first nbits) as SPI controller; din collects CIPO
    task automatic xfer(input int idx, input logic [W-1:0] dout, input int nbits,
                        output logic [W-1:0] din);
        logic pol, pha;
        int   b;
        pol = pol_of(idx);
        pha = pha_of(idx);
        din = '0;
        for (int i = 0; i < nbits; i++) begin
            b = (idx == 0) ? (W - 1 - i) : i;
            if (!pha) begin
                copi = dout[b];
                tick(H);
                din[b] = cipo_v[idx];
                sclk_set(idx, ~pol);
                tick(H);
                sclk_set(idx, pol);
            end else begin
                sclk_set(idx, ~pol);
                copi = dout[b];
                tick(H);
                din[b] = cipo_v[idx];
                sclk_set(idx, pol);
                tick(H);
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [W-1:0] din;
        logic [W-1:0] w1 [3];
        int lat, start, d0, a0, t0, r0, m;

        copi        = 1'b0;
        cs_n_v      = '1;
        rx_enable_v = '1;
        rx_ready_v  = '1;
        tx_valid_v  = '1;
        for (int g = 0; g < NI; g++) sclk_v[g] = pol_of(g);
        tx_seq[0] = '{8'h5A, 8'h5A, 8'h5A};
        for (int g = 1; g < NI; g++) tx_seq[g] = '{8'h81, 8'h42, 8'h00};

        tick(3);
        rst = 1'b0;
        tick(4);

        // Reset state
        check_eq("rst_rx_valid", rx_valid_v[0], 0);
        check_eq("rst_rx_data", rx_data_v[0], 0);
        check_eq("rst_word_count", word_count_v[0], 0);
        check_eq("rst_overflow", overflow_v[0], 0);
        check_eq("rst_underrun", underrun_v[0], 0);
        check_eq("rst_cipo_oe", cipo_oe_v, 0);
        check_eq("rst_cipo", cipo_v, 0);
        check_eq("rst_pulses", {frame_done_v, frame_abort_v, tx_ready_v}, 0);

        // Mode 0, MSB first, three words with the consumer always ready
        cur_idx = 0;
        w1 = '{8'hA5, 8'h3C, 8'hFF};
        d0 = done_cnt[0]; a0 = abort_cnt[0]; t0 = txr_cnt[0];
        cs_n_v[0] = 1'b0;
        tick(H);
        check_eq("t1_cipo_oe", cipo_oe_v[0], 1);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(w1[k]);
            xfer(0, w1[k], W, din);
            check_eq($sformatf("t1_cipo_w%0d", k), din, 8'h5A);
        end
        tick(H);
        cs_n_v[0] = 1'b1;
        start = cyc;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (frame_done_v[0]) begin
                lat = cyc - start;
                break;
            end
        end
        check_eq("t1_done_latency", lat, 3);
        tick(1);
        check_eq("t1_done_width", frame_done_v[0], 0);
        tick(4);
        check_eq("t1_word_count", word_count_v[0], 3);
        check_eq("t1_done_pulses", done_cnt[0] - d0, 1);
        check_eq("t1_abort_pulses", abort_cnt[0] - a0, 0);
        check_eq("t1_tx_ready_pulses", txr_cnt[0] - t0, 3);
        check_eq("t1_overflow", overflow_v[0], 0);
        sb_check("t1");

        // All four modes, LSB first, two-word frames
        for (int idx = 1; idx < NI; idx++) begin
            m = idx - 1;
            cur_idx = idx;
            d0 = done_cnt[idx]; a0 = abort_cnt[idx]; t0 = txr_cnt[idx];
            cs_n_v[idx] = 1'b0;
            tick(H);
            exp_q.push_back(8'h12);
            xfer(idx, 8'h12, W, din);
            check_eq($sformatf("m%0d_cipo_w0", m), din, 8'h81);
            exp_q.push_back(8'h34);
            xfer(idx, 8'h34, W, din);
            check_eq($sformatf("m%0d_cipo_w1", m), din, 8'h42);
            tick(H);
            cs_n_v[idx] = 1'b1;
            tick(8);
            check_eq($sformatf("m%0d_word_count", m), word_count_v[idx], 2);
            check_eq($sformatf("m%0d_done_pulses", m), done_cnt[idx] - d0, 1);
            check_eq($sformatf("m%0d_abort_pulses", m), abort_cnt[idx] - a0, 0);
            check_eq($sformatf("m%0d_tx_ready_pulses", m), txr_cnt[idx] - t0, 2);
            check_eq($sformatf("m%0d_underrun", m), underrun_v[idx], 0);
            sb_check($sformatf("m%0d", m));
        end

        // Consumer stalled for a whole frame: first word held, later words dropped
        cur_idx = 0;
        rx_ready_v[0] = 1'b0;
        d0 = done_cnt[0];
        cs_n_v[0] = 1'b0;
        tick(H);
        xfer(0, 8'h11, W, din);
        tick(4);
        check_eq("t3_rx_valid_w0", rx_valid_v[0], 1);
        check_eq("t3_rx_data_w0", rx_data_v[0], 8'h11);
        check_eq("t3_overflow_w0", overflow_v[0], 0);
        xfer(0, 8'h22, W, din);
        tick(4);
        check_eq("t3_overflow_w1", overflow_v[0], 1);
        check_eq("t3_rx_data_w1", rx_data_v[0], 8'h11);
        xfer(0, 8'h33, W, din);
        tick(H);
        cs_n_v[0] = 1'b1;
        tick(8);
        check_eq("t3_rx_valid_end", rx_valid_v[0], 1);
        check_eq("t3_rx_data_end", rx_data_v[0], 8'h11);
        check_eq("t3_word_count", word_count_v[0], 3);
        check_eq("t3_done_pulses", done_cnt[0] - d0, 1);
        rx_ready_v[0] = 1'b1;
        tick(1);
        check_eq("t3_rx_valid_drained", rx_valid_v[0], 0);
        tick(1);
        got_rd = got_q.size();

        // CS released after 5 bits of word 2
        d0 = done_cnt[0]; a0 = abort_cnt[0];
        cs_n_v[0] = 1'b0;
        tick(H);
        check_eq("t4_overflow_cleared", overflow_v[0], 0);
        exp_q.push_back(8'hC3);
        xfer(0, 8'hC3, W, din);
        xfer(0, 8'hFF, 5, din);
        tick(H);
        cs_n_v[0] = 1'b1;
        tick(8);
        check_eq("t4_abort_pulses", abort_cnt[0] - a0, 1);
        check_eq("t4_done_pulses", done_cnt[0] - d0, 0);
        check_eq("t4_word_count", word_count_v[0], 1);
        check_eq("t4_cipo_oe", cipo_oe_v[0], 0);
        sb_check("t4");

        // Next frame with no TX data: zeros on CIPO, underrun, no tx_ready
        tx_valid_v[0] = 1'b0;
        d0 = done_cnt[0]; t0 = txr_cnt[0];
        w1 = '{8'h01, 8'h80, 8'h7E};
        cs_n_v[0] = 1'b0;
        tick(H);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(w1[k]);
            xfer(0, w1[k], W, din);
            check_eq($sformatf("t6_cipo_w%0d", k), din, 8'h00);
        end
        tick(H);
        cs_n_v[0] = 1'b1;
        tick(8);
        check_eq("t6_underrun", underrun_v[0], 1);
        check_eq("t6_tx_ready_pulses", txr_cnt[0] - t0, 0);
        check_eq("t6_done_pulses", done_cnt[0] - d0, 1);
        check_eq("t6_word_count", word_count_v[0], 3);
        sb_check("t6");

        // SCLK stops mid-word: abort after the timeout, later edges ignored
        tx_valid_v[0] = 1'b1;
        d0 = done_cnt[0]; a0 = abort_cnt[0]; r0 = rxw_cnt[0];
        cs_n_v[0] = 1'b0;
        tick(H);
        check_eq("t5_underrun_cleared", underrun_v[0], 0);
        exp_q.push_back(8'h96);
        xfer(0, 8'h96, W, din);
        xfer(0, 8'h0F, 3, din);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (frame_abort_v[0]) begin
                lat = cyc - last_edge_cyc;
                break;
            end
        end
        check_eq("t5_timeout_latency", lat, 53);
        xfer(0, 8'hAA, W, din);
        tick(6);
        check_eq("t5_words_after_abort", rxw_cnt[0] - r0, 1);
        check_eq("t5_word_count", word_count_v[0], 1);
        check_eq("t5_cipo_oe", cipo_oe_v[0], 0);
        tick(H);
        cs_n_v[0] = 1'b1;
        tick(8);
        check_eq("t5_abort_pulses", abort_cnt[0] - a0, 1);
        check_eq("t5_done_pulses", done_cnt[0] - d0, 0);
        sb_check("t5");

        // rx_enable low: frame ignored silently
        rx_enable_v[0] = 1'b0;
        d0 = done_cnt[0]; a0 = abort_cnt[0]; r0 = rxw_cnt[0];
        cs_n_v[0] = 1'b0;
        tick(H);
        check_eq("t7_cipo_oe", cipo_oe_v[0], 0);
        xfer(0, 8'h55, W, din);
        tick(H);
        cs_n_v[0] = 1'b1;
        tick(8);
        check_eq("t7_rx_words", rxw_cnt[0] - r0, 0);
        check_eq("t7_abort_pulses", abort_cnt[0] - a0, 0);
        check_eq("t7_done_pulses", done_cnt[0] - d0, 0);
        check_eq("t7_word_count", word_count_v[0], 1);
        rx_enable_v[0] = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
